serial_shares_words_loader: RTL and testbench

Serial-to-parallel loader for masked (shared) AES data. It accepts one 32-bit word per handshake in share-major order: share 0 words 0..b, then share 1, and so on. It assembles the words into a full d-share parallel frame and presents that frame to the masked core through a valid/ready interface. It sits directly downstream of the serial bus interface and carries its own share/word index counter.

---
 rtl/serial_shares_words_loader_pkg.sv | 24 ++
 rtl/serial_shares_words_loader_index.sv | 69 ++++++
 rtl/serial_shares_words_loader.sv | 104 ++++++++++
 tb/tb_serial_shares_words_loader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_shares_words_loader_pkg.sv
// rtl/serial_shares_words_loader_pkg.sv - shared state encoding and slot helpers for the share loader
package serial_shares_words_loader_pkg;

   // Loader frame state: collecting words, or holding a complete frame.
   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } ldr_state_e;

   // A bound that would address past the last word slot is pinned to the last slot.
   function automatic int unsigned clamp_bound(input int unsigned bound,
                                               input int unsigned max_words);
      return (bound >= max_words) ? (max_words - 1) : bound;
   endfunction

   // Bit offset of (share, word) inside the share-major parallel frame.
   function automatic int unsigned slot_offset(input int unsigned share,
                                               input int unsigned word,
                                               input int unsigned max_words,
                                               input int unsigned word_width);
      return (share * max_words + word) * word_width;
   endfunction

endpackage

// File: rtl/serial_shares_words_loader_index.sv
// rtl/serial_shares_words_loader_index.sv - share/word index counter with latched per-frame bound
module serial_share_word_index
   import serial_shares_words_loader_pkg::*;
#(
   parameter int unsigned D                   = 2,
   parameter int unsigned NBITS               = 4,
   parameter int unsigned MAX_WORDS_PER_SHARE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             inc_i,
   input  logic [NBITS-1:0] bound_i,
   output logic [NBITS-1:0] share_idx_o,
   output logic [NBITS-1:0] word_idx_o,
   output logic             last_o
);

   logic [NBITS-1:0] share_q, share_d;
   logic [NBITS-1:0] word_q, word_d;
   logic [NBITS-1:0] bound_q, bound_d;
   logic [NBITS-1:0] bound_clamped;
   logic [NBITS-1:0] bound_eff;
   logic             first_word;

   // The first word of a frame uses the live bound; later words use the latched copy.
   assign bound_clamped = NBITS'(clamp_bound(32'(bound_i), MAX_WORDS_PER_SHARE));
   assign first_word    = (share_q == '0) && (word_q == '0);
   assign bound_eff     = first_word ? bound_clamped : bound_q;
   assign last_o        = (share_q == NBITS'(D - 1)) && (word_q == bound_eff);

   assign share_idx_o = share_q;
   assign word_idx_o  = word_q;

   // Next-index decode: clear wins, otherwise advance word then share, wrapping after the last word.
   always_comb begin
      share_d = share_q;
      word_d  = word_q;
      bound_d = bound_q;
      if (clear_i) begin
         share_d = '0;
         word_d  = '0;
      end else if (inc_i) begin
         if (first_word) begin
            bound_d = bound_clamped;
         end
         if (word_q == bound_eff) begin
            word_d  = '0;
            share_d = last_o ? '0 : share_q + 1'b1;
         end else begin
            word_d = word_q + 1'b1;
         end
      end
   end

   // Index and bound registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         share_q <= '0;
         word_q  <= '0;
         bound_q <= '0;
      end else begin
         share_q <= share_d;
         word_q  <= word_d;
         bound_q <= bound_d;
      end
   end

endmodule

// File: rtl/serial_shares_words_loader.sv
// rtl/serial_shares_words_loader.sv - serial-to-parallel loader assembling d-share frames for the masked core
module serial_shares_words_loader
   import serial_shares_words_loader_pkg::*;
#(
   parameter int unsigned d                   = 2,
   parameter int unsigned NBITS               = 4,
   parameter int unsigned MAX_WORDS_PER_SHARE = 8,
   parameter int unsigned WORD_WIDTH          = 32
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       clear,
   input  logic [NBITS-1:0]                           words_per_share_bound,
   input  logic [WORD_WIDTH-1:0]                      in_data,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   output logic [d*MAX_WORDS_PER_SHARE*WORD_WIDTH-1:0] out_data,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [NBITS-1:0]                           share_idx,
   output logic [NBITS-1:0]                           word_idx
);

   localparam int unsigned FRAME_W = d * MAX_WORDS_PER_SHARE * WORD_WIDTH;

   ldr_state_e         state_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [FRAME_W-1:0] out_data_q;
   logic [FRAME_W-1:0] out_data_d;
   logic               in_hs;
   logic               idx_last;
   logic [NBITS-1:0]   share_idx_w;
   logic [NBITS-1:0]   word_idx_w;

   // in_ready_q is only ever high in FILL, so a handshake implies FILL.
   assign in_hs = in_valid & in_ready_q;

   serial_share_word_index #(
      .D                   (d),
      .NBITS               (NBITS),
      .MAX_WORDS_PER_SHARE (MAX_WORDS_PER_SHARE)
   ) u_index (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear),
      .inc_i       (in_hs),
      .bound_i     (words_per_share_bound),
      .share_idx_o (share_idx_w),
      .word_idx_o  (word_idx_w),
      .last_o      (idx_last)
   );

   // Write decode: the frame with the incoming word merged into its share-major slot.
   always_comb begin
      int unsigned off;
      off        = slot_offset(32'(share_idx_w), 32'(word_idx_w), MAX_WORDS_PER_SHARE, WORD_WIDTH);
      out_data_d = out_data_q;
      out_data_d[off +: WORD_WIDTH] = in_data;
   end

   // Frame FSM with registered handshake outputs; clear overrides any coincident handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FILL;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (clear) begin
         state_q     <= ST_FILL;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (in_hs) begin
                  out_data_q <= out_data_d;
                  if (idx_last) begin
                     state_q     <= ST_FULL;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  state_q     <= ST_FILL;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  out_data_q  <= '0;
               end
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign share_idx = share_idx_w;
   assign word_idx  = word_idx_w;

endmodule

// File: tb/tb_serial_shares_words_loader.sv
// tb/tb_serial_shares_words_loader.sv - self-checking bench for the share loader against a frame model
module tb_serial_shares_words_loader;

   localparam int D  = 2;
   localparam int NB = 4;
   localparam int MW = 8;
   localparam int WW = 32;
   localparam int FW = D * MW * WW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic [NB-1:0] bound;
   logic [WW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [FW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [NB-1:0] share_idx;
   logic [NB-1:0] word_idx;

   always #5 clk = ~clk;

   serial_shares_words_loader #(
      .d                   (D),
      .NBITS               (NB),
      .MAX_WORDS_PER_SHARE (MW),
      .WORD_WIDTH          (WW)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .clear                 (clear),
      .words_per_share_bound (bound),
      .in_data               (in_data),
      .in_valid              (in_valid),
      .in_ready              (in_ready),
      .out_data              (out_data),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .share_idx             (share_idx),
      .word_idx              (word_idx)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: words accepted so far in this frame, latched words-per-share, frame contents.
   int            m_cnt;
   int            m_wps;
   bit            m_full;
   logic [WW-1:0] m_slot [D*MW];

   function automatic logic [FW-1:0] m_frame();
      logic [FW-1:0] f;
      f = '0;
      for (int s = 0; s < D * MW; s++) f[s*WW +: WW] = m_slot[s];
      return f;
   endfunction

   task automatic model_reset();
      m_cnt  = 0;
      m_full = 0;
      m_wps  = 1;
      for (int s = 0; s < D * MW; s++) m_slot[s] = '0;
   endtask

   task automatic model_step();
      if (clear) begin
         m_cnt  = 0;
         m_full = 0;
         for (int s = 0; s < D * MW; s++) m_slot[s] = '0;
      end else if (!m_full) begin
         if (in_valid) begin
            if (m_cnt == 0) m_wps = ((int'(bound) > MW - 1) ? MW - 1 : int'(bound)) + 1;
            m_slot[(m_cnt / m_wps) * MW + (m_cnt % m_wps)] = in_data;
            m_cnt++;
            if (m_cnt == D * m_wps) begin
               m_full = 1;
               m_cnt  = 0;
            end
         end
      end else if (out_ready) begin
         m_full = 0;
         for (int s = 0; s < D * MW; s++) m_slot[s] = '0;
      end
   endtask

   task automatic check_all(input string ph);
      check_eq({ph, "_in_ready"},  FW'(in_ready),  FW'(!m_full));
      check_eq({ph, "_out_valid"}, FW'(out_valid), FW'(m_full));
      check_eq({ph, "_share_idx"}, FW'(share_idx), FW'(m_cnt / m_wps));
      check_eq({ph, "_word_idx"},  FW'(word_idx),  FW'(m_cnt % m_wps));
      check_eq({ph, "_out_data"},  out_data,       m_frame());
   endtask

   // One clock: apply inputs at the falling edge, update model at the rising edge, compare at the next fall.
   task automatic cyc(input string ph, input logic v, input logic [WW-1:0] data,
                      input logic ordy, input logic clr, input logic [NB-1:0] bnd);
      in_valid  = v;
      in_data   = data;
      out_ready = ordy;
      clear     = clr;
      bound     = bnd;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(ph);
   endtask

   logic [FW-1:0] exp_frame;

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      bound     = 4'd3;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("rst_low");
      rst_n = 1'b1;
      @(negedge clk);
      check_all("rst_rel");

      // Nominal frame, bound 3
      for (int i = 1; i <= 8; i++) cyc("nom", 1'b1, WW'(i), 1'b0, 1'b0, 4'd3);
      exp_frame = '0;
      for (int i = 0; i < 4; i++) begin
         exp_frame[i*WW +: WW]       = WW'(i + 1);
         exp_frame[(i + 8)*WW +: WW] = WW'(i + 5);
      end
      check_eq("nom_frame_const", out_data, exp_frame);
      check_eq("nom_out_valid_const", FW'(out_valid), FW'(1));

      // Backpressure then a bound change during the next frame
      repeat (5) cyc("bp", 1'b1, $urandom, 1'b0, 1'b0, 4'd3);
      check_eq("bp_frame_stable", out_data, exp_frame);
      cyc("bp_out", 1'b0, '0, 1'b1, 1'b0, 4'd3);
      for (int i = 0; i < 8; i++) begin
         cyc("bchg", 1'b1, $urandom, 1'b0, 1'b0, (i >= 2) ? 4'd1 : 4'd3);
         check_eq("bchg_valid_const", FW'(out_valid), FW'(i == 7));
      end
      cyc("bchg_out", 1'b0, '0, 1'b1, 1'b0, 4'd1);

      // Clamp: bound 15 behaves as 7, sixteen words fill every slot
      for (int i = 0; i < 16; i++) cyc("clamp", 1'b1, $urandom, 1'b0, 1'b0, 4'd15);
      check_eq("clamp_full_const", FW'(out_valid), FW'(1));
      cyc("clamp_out", 1'b0, '0, 1'b1, 1'b0, 4'd15);
      check_eq("clamp_wrap_idx", FW'({share_idx, word_idx}), FW'(0));

      // Clear coincident with the 4th word handshake
      for (int i = 0; i < 3; i++) cyc("clr", 1'b1, $urandom, 1'b0, 1'b0, 4'd3);
      cyc("clr_hit", 1'b1, 32'hdead_beef, 1'b0, 1'b1, 4'd3);
      check_eq("clr_idx_zero", FW'({share_idx, word_idx}), FW'(0));
      for (int i = 0; i < 8; i++) cyc("clr_frame", 1'b1, $urandom, 1'b0, 1'b0, 4'd3);
      cyc("clr_out", 1'b0, '0, 1'b1, 1'b0, 4'd3);

      // Asynchronous reset between clock edges after 5 words
      for (int i = 0; i < 5; i++) cyc("arst", 1'b1, $urandom, 1'b0, 1'b0, 4'd3);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("arst_low");
      @(negedge clk);
      rst_n = 1'b1;
      check_all("arst_rel");
      for (int i = 0; i < 8; i++) cyc("arst_frame", 1'b1, $urandom, 1'b0, 1'b0, 4'd3);
      cyc("arst_out", 1'b0, '0, 1'b1, 1'b0, 4'd3);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         cyc("rnd", $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
             $urandom_range(0, 63) == 0, NB'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
